datamem_arbiter: RTL

DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

---
 rtl/datamem_pkg.sv | 15 +
 rtl/datamem_req_fifo.sv | 53 +++++
 rtl/datamem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/datamem_pkg.sv
// Shared widths, owner encoding and request-entry layout for the data-memory arbiter.
package datamem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {OWN_IDLE, OWN_HOST, OWN_CPU, OWN_ACCEL} owner_t;

  // 49-bit queue entry, packed as {wrt_en, addr, data}
  typedef struct packed {
    logic              wrt_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;
endpackage

// File: rtl/datamem_req_fifo.sv
// Accel request queue: head visible combinationally, pop takes effect at the clock edge.
// A push is accepted only when not full; popping an empty queue is ignored.
module datamem_req_fifo
  import datamem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t push_req,
  input  logic pop,
  output logic full,
  output logic empty,
  output req_t head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth: pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end
endmodule

// File: rtl/datamem_arbiter.sv
// Data-memory arbiter: host > CPU > accel queue, combinational grant, read strobes one cycle later.
// DATAMEM_ARB_STARVE_EN: a starved accel head beats the CPU once after STARVE_LIMIT waiting cycles.
module datamem_arbiter
  import datamem_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_wrt_en,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wrt_data,
  input  logic              cpu_req,
  input  logic              cpu_wrt_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wrt_data,
  output logic              cpu_gnt,
  input  logic              accel_valid,
  output logic              accel_ready,
  input  logic              accel_wrt_en,
  input  logic [ADDR_W-1:0] accel_addr,
  input  logic [DATA_W-1:0] accel_wrt_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrt_data,
  output logic              mem_wrt_en,
  output logic              mem_rd_en,
  output logic              cpu_rd_valid,
  output logic              accel_rd_valid
);
  owner_t grant;
  owner_t owner;
  logic   last_rd;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_pop;
  logic   starve_force;
  req_t   head;
  req_t   push_req;

  assign push_req    = '{wrt_en: accel_wrt_en, addr: accel_addr, data: accel_wrt_data};
  assign accel_ready = !fifo_full;
  assign fifo_pop    = (grant == OWN_ACCEL);
  assign cpu_gnt     = (grant == OWN_CPU);

  datamem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accel_valid && accel_ready),
    .push_req (push_req),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

`ifdef DATAMEM_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  // Saturates at the limit so a host burst cannot wrap it back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              starve_cnt <= '0;
    else if (fifo_pop)                                       starve_cnt <= '0;
    else if (!fifo_empty && starve_cnt != SC_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SC_W'(1);
  end

  assign starve_force = (starve_cnt == SC_W'(STARVE_LIMIT)) && !fifo_empty;
`else
  // Strict-priority build keeps the parameter only for a uniform instance interface
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign starve_force        = 1'b0;
`endif

  always_comb begin
    grant = OWN_IDLE;
    if (ex_wrt_en)                      grant = OWN_HOST;
    else if (starve_force)              grant = OWN_ACCEL;
    else if (cpu_req)                   grant = OWN_CPU;
    else if (!fifo_empty)               grant = OWN_ACCEL;
  end

  always_comb begin
    mem_addr     = '0;
    mem_wrt_data = '0;
    mem_wrt_en   = 1'b0;
    mem_rd_en    = 1'b0;
    case (grant)
      OWN_HOST: begin
        mem_addr     = ex_addr;
        mem_wrt_data = ex_wrt_data;
        mem_wrt_en   = 1'b1;
      end
      OWN_CPU: begin
        mem_addr     = cpu_addr;
        mem_wrt_data = cpu_wrt_data;
        mem_wrt_en   = cpu_wrt_en;
        mem_rd_en    = !cpu_wrt_en;
      end
      OWN_ACCEL: begin
        mem_addr     = head.addr;
        mem_wrt_data = head.data;
        mem_wrt_en   = head.wrt_en;
        mem_rd_en    = !head.wrt_en;
      end
      default: ;
    endcase
  end

  // Owner remembers last cycle's grant; read-return strobes follow from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= OWN_IDLE;
      last_rd <= 1'b0;
    end else begin
      owner   <= grant;
      last_rd <= mem_rd_en;
    end
  end

  assign cpu_rd_valid   = (owner == OWN_CPU)   && last_rd;
  assign accel_rd_valid = (owner == OWN_ACCEL) && last_rd;
endmodule
